// File: rtl/line_endpoint_capture_pkg.sv
// Shared types for the line endpoint capture block: FSM states, point struct, coordinate widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package line_pkg;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int DW = 12;  // signed difference width, wide enough for either axis

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_P1 = 2'd1,
        PENDING = 2'd2,
        DRAWN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } point_t;

    // |a - b| on zero-extended coordinates; the result always fits in DW-1 bits.
    function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] d;
        d = a - b;
        return d[DW-1] ? (~d + 1'b1) : d;
    endfunction

endpackage

// File: rtl/line_endpoint_capture_centroid_stability.sv
// Tracks whether the per-frame centroid has held still for STABLE_FRAMES frames within TOL.
// Latency: prev/stable update on the cycle after the new_frame pulse.
// Backpressure: none; samples only on new_frame.
module centroid_stability
    import line_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int TOL           = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_frame,
    input  logic [XW-1:0] x_com,
    input  logic [YW-1:0] y_com,
    input  logic          com_valid,
    output point_t        prev,
    output logic          stable
);

    localparam int CW = $clog2(STABLE_FRAMES + 1);

    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [DW-1:0] dx;
    logic [DW-1:0] dy;
    logic          still;

    // Per-axis movement against the previous valid centroid and the next count value.
    always_comb begin
        dx      = abs_diff({1'b0, x_com}, {1'b0, prev.x});
        dy      = abs_diff({2'b00, y_com}, {2'b00, prev.y});
        still   = (dx <= DW'(TOL)) && (dy <= DW'(TOL));
        cnt_nxt = stable_cnt;
        if (!com_valid) begin
            cnt_nxt = '0;
        end else if (still) begin
            if (stable_cnt != CW'(STABLE_FRAMES))
                cnt_nxt = stable_cnt + 1'b1;
        end else begin
            cnt_nxt = '0;
        end
    end

    // Counter, stable flag and previous centroid advance only on frame pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= '0;
            stable     <= 1'b0;
            prev       <= '0;
        end else if (new_frame) begin
            stable_cnt <= cnt_nxt;
            stable     <= (cnt_nxt == CW'(STABLE_FRAMES));
            if (com_valid)
                prev <= '{x: x_com, y: y_com};
        end
    end

endmodule

// File: rtl/line_endpoint_capture.sv
// Captures two still centroid endpoints on capture pulses and publishes the segment frame-aligned.
// Latency: p2 capture to visible line lands on the first later new_frame pulse (1-2 frames).
// Backpressure: none; captures while unstable, too short, or pending are dropped.
module line_endpoint_capture
    import line_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int TOL           = 2,
    parameter int MIN_LEN       = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          new_frame_in,
    input  logic [XW-1:0] x_com_in,
    input  logic [YW-1:0] y_com_in,
    input  logic          com_valid_in,
    input  logic          capture_in,
    input  logic          clear_in,
    output logic [XW-1:0] x_out_1,
    output logic [YW-1:0] y_out_1,
    output logic [XW-1:0] x_out_2,
    output logic [YW-1:0] y_out_2,
    output logic          line_valid_out,
    output logic          stable_out,
    output logic [1:0]    state_out
);

    state_t state, state_nxt;
    point_t prev, p1, p2, out1, out2;
    logic   stable;
    logic   clear_pend;
    logic   latch_p1, latch_p2, commit;
    logic   cap_ok;
    logic [DW:0] seg_len;

    centroid_stability #(
        .STABLE_FRAMES(STABLE_FRAMES),
        .TOL          (TOL)
    ) u_stab (
        .clk      (clk_in),
        .rst      (rst_in),
        .new_frame(new_frame_in),
        .x_com    (x_com_in),
        .y_com    (y_com_in),
        .com_valid(com_valid_in),
        .prev     (prev),
        .stable   (stable)
    );

    // Next state and datapath strobes; clear wins over everything else in its cycle.
    always_comb begin
        state_nxt = state;
        latch_p1  = 1'b0;
        latch_p2  = 1'b0;
        commit    = 1'b0;
        cap_ok    = capture_in && stable;
        seg_len   = {1'b0, abs_diff({1'b0, prev.x}, {1'b0, p1.x})}
                  + {1'b0, abs_diff({2'b00, prev.y}, {2'b00, p1.y})};
        if (clear_in) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (cap_ok) begin
                    latch_p1  = 1'b1;
                    state_nxt = HAVE_P1;
                end
                HAVE_P1: if (cap_ok && (seg_len >= (DW+1)'(MIN_LEN))) begin
                    latch_p2  = 1'b1;
                    state_nxt = PENDING;
                end
                PENDING: if (new_frame_in) begin
                    commit    = 1'b1;
                    state_nxt = DRAWN;
                end
                DRAWN: if (cap_ok) begin
                    latch_p1  = 1'b1;
                    state_nxt = HAVE_P1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Pending endpoints: captured from the registered centroid, erased by clear.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            if (latch_p1) p1 <= prev;
            if (latch_p2) p2 <= prev;
        end
    end

    // Published segment only moves on frame pulses: either a deferred clear or a commit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out1           <= '0;
            out2           <= '0;
            line_valid_out <= 1'b0;
            clear_pend     <= 1'b0;
        end else begin
            if (new_frame_in && clear_pend) begin
                out1           <= '0;
                out2           <= '0;
                line_valid_out <= 1'b0;
            end else if (commit) begin
                out1           <= p1;
                out2           <= p2;
                line_valid_out <= 1'b1;
            end
            if (clear_in)
                clear_pend <= 1'b1;
            else if (new_frame_in)
                clear_pend <= 1'b0;
        end
    end

    assign x_out_1    = out1.x;
    assign y_out_1    = out1.y;
    assign x_out_2    = out2.x;
    assign y_out_2    = out2.y;
    assign stable_out = stable;
    assign state_out  = state;

endmodule

// File: tb/tb_line_endpoint_capture.sv
// Directed bench for line_endpoint_capture with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after the following posedge.
// Backpressure: n/a.
module tb_line_endpoint_capture;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        new_frame_in;
    logic [10:0] x_com_in;
    logic [9:0]  y_com_in;
    logic        com_valid_in;
    logic        capture_in;
    logic        clear_in;
    logic [10:0] x_out_1;
    logic [9:0]  y_out_1;
    logic [10:0] x_out_2;
    logic [9:0]  y_out_2;
    logic        line_valid_out;
    logic        stable_out;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    line_endpoint_capture dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .new_frame_in  (new_frame_in),
        .x_com_in      (x_com_in),
        .y_com_in      (y_com_in),
        .com_valid_in  (com_valid_in),
        .capture_in    (capture_in),
        .clear_in      (clear_in),
        .x_out_1       (x_out_1),
        .y_out_1       (y_out_1),
        .x_out_2       (x_out_2),
        .y_out_2       (y_out_2),
        .line_valid_out(line_valid_out),
        .stable_out    (stable_out),
        .state_out     (state_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected published segment as one check each for both endpoints and valid.
    task automatic chk_line(input string tag, input int ex1, input int ey1, input int ex2,
                            input int ey2, input logic ev);
        chk({tag, ".x1"}, 32'(x_out_1), 32'(ex1));
        chk({tag, ".y1"}, 32'(y_out_1), 32'(ey1));
        chk({tag, ".x2"}, 32'(x_out_2), 32'(ex2));
        chk({tag, ".y2"}, 32'(y_out_2), 32'(ey2));
        chk({tag, ".vld"}, 32'(line_valid_out), 32'(ev));
    endtask

    // One clock cycle of stimulus; single-cycle pulses drop afterwards.
    task automatic step(input logic nf, input int x, input int y, input logic v,
                        input logic cap, input logic clr);
        @(posedge clk_in);
        #1;
        new_frame_in = nf;
        x_com_in     = 11'(x);
        y_com_in     = 10'(y);
        com_valid_in = v;
        capture_in   = cap;
        clear_in     = clr;
        @(posedge clk_in);
        #1;
        new_frame_in = 1'b0;
        capture_in   = 1'b0;
        clear_in     = 1'b0;
    endtask

    task automatic frame(input int x, input int y);
        step(1'b1, x, y, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic frames(input int x, input int y, input int n);
        for (int i = 0; i < n; i++) frame(x, y);
    endtask

    task automatic capture();
        step(1'b0, int'(x_com_in), int'(y_com_in), com_valid_in, 1'b1, 1'b0);
    endtask

    initial begin
        rst_in       = 1'b1;
        new_frame_in = 1'b0;
        x_com_in     = '0;
        y_com_in     = '0;
        com_valid_in = 1'b0;
        capture_in   = 1'b0;
        clear_in     = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Reset state
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_stable", 32'(stable_out), 32'd0);
        chk_line("rst_line", 0, 0, 0, 0, 1'b0);

        // Stability: first frame differs from prev=(0,0), then counts 1,2,3
        frames(100, 50, 2);
        chk("stab_f2", 32'(stable_out), 32'd0);
        frames(100, 50, 2);
        chk("stab_f4", 32'(stable_out), 32'd1);
        frame(100, 50);
        chk("stab_f5", 32'(stable_out), 32'd1);
        chk("stab_vld", 32'(line_valid_out), 32'd0);
        chk("stab_state", 32'(state_out), 32'd0);

        // Jitter: (102,51) within TOL, (105,51) moves 3 in x and resets
        frame(100, 50);
        frame(102, 51);
        chk("jit_still", 32'(stable_out), 32'd1);
        frame(105, 51);
        chk("jit_reset", 32'(stable_out), 32'd0);
        capture();
        chk("jit_cap_ignored", 32'(state_out), 32'd0);

        // Two-point commit
        frames(100, 50, 4);
        chk("p1_stable", 32'(stable_out), 32'd1);
        capture();
        chk("p1_state", 32'(state_out), 32'd1);
        frames(300, 200, 4);
        capture();
        chk("p2_state", 32'(state_out), 32'd2);
        chk_line("pending_line", 0, 0, 0, 0, 1'b0);
        capture();
        chk("pending_cap_ignored", 32'(state_out), 32'd2);
        frame(300, 200);
        chk("commit_state", 32'(state_out), 32'd3);
        chk_line("commit_line", 100, 50, 300, 200, 1'b1);
        repeat (4) @(posedge clk_in);
        #1;
        chk_line("hold_line", 100, 50, 300, 200, 1'b1);

        // Redraw with a rejected short second point
        frames(100, 50, 4);
        capture();
        chk("redraw_state", 32'(state_out), 32'd1);
        chk_line("redraw_old_line", 100, 50, 300, 200, 1'b1);
        frames(103, 53, 4);
        chk("short_stable", 32'(stable_out), 32'd1);
        capture();
        chk("short_ignored", 32'(state_out), 32'd1);
        frames(110, 50, 4);
        chk_line("redraw_still_old", 100, 50, 300, 200, 1'b1);
        capture();
        chk("len10_state", 32'(state_out), 32'd2);
        frame(110, 50);
        chk("recommit_state", 32'(state_out), 32'd3);
        chk_line("recommit_line", 100, 50, 110, 50, 1'b1);

        // Clear beats capture; outputs drop on the next frame pulse only
        step(1'b0, 110, 50, 1'b1, 1'b1, 1'b1);
        chk("clear_state", 32'(state_out), 32'd0);
        chk_line("clear_deferred", 100, 50, 110, 50, 1'b1);
        frame(110, 50);
        chk_line("clear_applied", 0, 0, 0, 0, 1'b0);
        chk("clear_state2", 32'(state_out), 32'd0);

        // Invalid centroid frame drops stability
        chk("inv_before", 32'(stable_out), 32'd1);
        step(1'b1, 110, 50, 1'b0, 1'b0, 1'b0);
        chk("inv_after", 32'(stable_out), 32'd0);

        // Reset mid-operation
        frames(110, 50, 3);
        chk("rst2_stable_pre", 32'(stable_out), 32'd1);
        capture();
        chk("rst2_state_pre", 32'(state_out), 32'd1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk("rst2_state", 32'(state_out), 32'd0);
        chk("rst2_stable", 32'(stable_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
